// File: rtl/serial_sub_nbit_if.sv
// Handshake and operand/result bundle for serial_sub_nbit.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub_nbit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, x, y, bin,
`ifdef SERIAL_SUB_OVF_EN
    input  ovf,
`endif
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, x, y, bin,
`ifdef SERIAL_SUB_OVF_EN
    output ovf,
`endif
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_sub_nbit.sv
// Multi-cycle subtractor: diff = x - y - bin, STEP bits per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the registered two's-complement overflow flag.
module serial_sub_nbit #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input logic              clk,
  input logic              rst_n,
  serial_sub_nbit_if.slave bus
);
  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (WIDTH < 2 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_param_check
    $error("serial_sub_nbit: WIDTH must be >= 2 and a multiple of STEP");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] x_sh, y_sh;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic [STEP-1:0]  d_slice;
  logic [STEP:0]    chain;    // chain[i] is the borrow into cell i
  logic [WIDTH-1:0] res_nxt;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin : sub_chain
    chain   = '0;
    d_slice = '0;
    chain[0] = br;
    for (int i = 0; i < STEP; i++) begin
      d_slice[i]  = x_sh[i] ^ y_sh[i] ^ chain[i];
      chain[i+1]  = (~x_sh[i] & y_sh[i]) | (~(x_sh[i] ^ y_sh[i]) & chain[i]);
    end
  end

  assign last = (cnt == LAST);

  // Partial result fills from the MSB side; only WIDTH-STEP bits need storing
  // because the final slice is merged straight into diff.
  if (STEP < WIDTH) begin : g_res
    logic [WIDTH-STEP-1:0] res;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        res <= '0;
      end else if (state == RUN) begin
        res <= res_nxt[WIDTH-1:STEP];
      end
    end

    assign res_nxt = {d_slice, res};
  end else begin : g_res_single
    assign res_nxt = d_slice;
  end

  always_comb begin : fsm_next
    state_nxt = state;
    bus.busy  = 1'b0;
    case (state)
      IDLE: if (bus.start) state_nxt = RUN;
      RUN: begin
        bus.busy = 1'b1;
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin : fsm_state
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin : datapath
    if (!rst_n) begin
      x_sh     <= '0;
      y_sh     <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      bus.done <= 1'b0;
      bus.diff <= '0;
      bus.bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      bus.ovf  <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            x_sh <= bus.x;
            y_sh <= bus.y;
            br   <= bus.bin;
            cnt  <= '0;
          end
        end
        RUN: begin
          x_sh <= x_sh >> STEP;
          y_sh <= y_sh >> STEP;
          br   <= chain[STEP];
          cnt  <= cnt + 1'b1;
          if (last) begin
            bus.diff <= res_nxt;
            bus.bout <= chain[STEP];
            bus.done <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            // Overflow when borrow into and out of the sign cell disagree.
            bus.ovf  <= chain[STEP] ^ chain[STEP-1];
`endif
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_sub_nbit.sv
// Directed self-checking bench for serial_sub_nbit across four WIDTH/STEP builds.
// Expected values are hand-computed constants or an integer reference for WIDTH=2.
module tb_serial_sub_nbit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  serial_sub_nbit_if #(.WIDTH(8)) if8_1 ();
  serial_sub_nbit_if #(.WIDTH(8)) if8_4 ();
  serial_sub_nbit_if #(.WIDTH(2)) if2_1 ();
  serial_sub_nbit_if #(.WIDTH(2)) if2_2 ();

  serial_sub_nbit #(.WIDTH(8), .STEP(1)) dut8_1 (.clk(clk), .rst_n(rst_n), .bus(if8_1));
  serial_sub_nbit #(.WIDTH(8), .STEP(4)) dut8_4 (.clk(clk), .rst_n(rst_n), .bus(if8_4));
  serial_sub_nbit #(.WIDTH(2), .STEP(1)) dut2_1 (.clk(clk), .rst_n(rst_n), .bus(if2_1));
  serial_sub_nbit #(.WIDTH(2), .STEP(2)) dut2_2 (.clk(clk), .rst_n(rst_n), .bus(if2_2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Each op task: apply start for one edge, then wait (bounded) for done.
  // cyc = edges after the accepting edge until done is seen; busy_n = busy samples.
  task automatic op8_1(input logic [7:0] a, input logic [7:0] b, input logic c,
                       output int cyc, output int busy_n);
    if8_1.x = a; if8_1.y = b; if8_1.bin = c; if8_1.start = 1'b1;
    step();
    if8_1.start = 1'b0;
    cyc = 0; busy_n = 0;
    while (!if8_1.done && cyc < 40) begin
      if (if8_1.busy) busy_n++;
      step();
      cyc++;
    end
    if (if8_1.busy) busy_n++;
  endtask

  task automatic op8_4(input logic [7:0] a, input logic [7:0] b, input logic c,
                       output int cyc, output int busy_n);
    if8_4.x = a; if8_4.y = b; if8_4.bin = c; if8_4.start = 1'b1;
    step();
    if8_4.start = 1'b0;
    cyc = 0; busy_n = 0;
    while (!if8_4.done && cyc < 40) begin
      if (if8_4.busy) busy_n++;
      step();
      cyc++;
    end
    if (if8_4.busy) busy_n++;
  endtask

  task automatic op2_1(input logic [1:0] a, input logic [1:0] b, input logic c, output int cyc);
    if2_1.x = a; if2_1.y = b; if2_1.bin = c; if2_1.start = 1'b1;
    step();
    if2_1.start = 1'b0;
    cyc = 0;
    while (!if2_1.done && cyc < 40) begin step(); cyc++; end
  endtask

  task automatic op2_2(input logic [1:0] a, input logic [1:0] b, input logic c, output int cyc);
    if2_2.x = a; if2_2.y = b; if2_2.bin = c; if2_2.start = 1'b1;
    step();
    if2_2.start = 1'b0;
    cyc = 0;
    while (!if2_2.done && cyc < 40) begin step(); cyc++; end
  endtask

  task automatic test_reset();
    #3;
    vecs++;
    if (if8_1.busy !== 1'b0 || if8_1.done !== 1'b0 || if8_1.diff !== 8'h00 || if8_1.bout !== 1'b0) begin
      errs++;
      $display("FAIL reset_8_1: busy=%b done=%b diff=%h bout=%b, want all zero",
               if8_1.busy, if8_1.done, if8_1.diff, if8_1.bout);
    end
    vecs++;
    if (if8_4.busy !== 1'b0 || if8_4.diff !== 8'h00 || if2_2.diff !== 2'b00) begin
      errs++;
      $display("FAIL reset_others: busy8_4=%b diff8_4=%h diff2_2=%b, want zero",
               if8_4.busy, if8_4.diff, if2_2.diff);
    end
`ifdef SERIAL_SUB_OVF_EN
    vecs++;
    if (if8_1.ovf !== 1'b0) begin
      errs++;
      $display("FAIL reset_ovf: got %b want 0", if8_1.ovf);
    end
`endif
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int cyc, busy_n;
    op8_1(8'h5A, 8'h3C, 1'b0, cyc, busy_n);
    vecs++;
    if (cyc !== 8 || busy_n !== 8) begin
      errs++;
      $display("FAIL basic_latency: cyc=%0d busy=%0d want 8/8", cyc, busy_n);
    end
    vecs++;
    if (if8_1.diff !== 8'h1E || if8_1.bout !== 1'b0) begin
      errs++;
      $display("FAIL basic_result: got %h/%b want 1e/0", if8_1.diff, if8_1.bout);
    end
    step();
    vecs++;
    if (if8_1.done !== 1'b0 || if8_1.diff !== 8'h1E) begin
      errs++;
      $display("FAIL basic_pulse: done=%b diff=%h want 0/1e", if8_1.done, if8_1.diff);
    end
    op8_1(8'h5A, 8'h3C, 1'b1, cyc, busy_n);
    vecs++;
    if (if8_1.diff !== 8'h1D || if8_1.bout !== 1'b0) begin
      errs++;
      $display("FAIL basic_bin: got %h/%b want 1d/0", if8_1.diff, if8_1.bout);
    end
  endtask

  task automatic test_wrap();
    int cyc, busy_n;
    op8_1(8'h00, 8'h01, 1'b0, cyc, busy_n);
    vecs++;
    if (if8_1.diff !== 8'hFF || if8_1.bout !== 1'b1) begin
      errs++;
      $display("FAIL wrap_0m1: got %h/%b want ff/1", if8_1.diff, if8_1.bout);
    end
`ifdef SERIAL_SUB_OVF_EN
    vecs++;
    if (if8_1.ovf !== 1'b0) begin
      errs++;
      $display("FAIL wrap_0m1_ovf: got %b want 0", if8_1.ovf);
    end
`endif
    op8_1(8'h80, 8'h01, 1'b0, cyc, busy_n);
    vecs++;
    if (if8_1.diff !== 8'h7F || if8_1.bout !== 1'b0) begin
      errs++;
      $display("FAIL wrap_80m1: got %h/%b want 7f/0", if8_1.diff, if8_1.bout);
    end
`ifdef SERIAL_SUB_OVF_EN
    vecs++;
    if (if8_1.ovf !== 1'b1) begin
      errs++;
      $display("FAIL wrap_80m1_ovf: got %b want 1", if8_1.ovf);
    end
`endif
    op8_1(8'h7F, 8'hFF, 1'b0, cyc, busy_n);
    vecs++;
    if (if8_1.diff !== 8'h80 || if8_1.bout !== 1'b1) begin
      errs++;
      $display("FAIL wrap_7fmff: got %h/%b want 80/1", if8_1.diff, if8_1.bout);
    end
`ifdef SERIAL_SUB_OVF_EN
    vecs++;
    if (if8_1.ovf !== 1'b1) begin
      errs++;
      $display("FAIL wrap_7fmff_ovf: got %b want 1", if8_1.ovf);
    end
`endif
  endtask

  task automatic test_step4();
    int cyc, busy_n;
    op8_4(8'h10, 8'h0F, 1'b1, cyc, busy_n);
    vecs++;
    if (cyc !== 2 || busy_n !== 2) begin
      errs++;
      $display("FAIL step4_latency: cyc=%0d busy=%0d want 2/2", cyc, busy_n);
    end
    vecs++;
    if (if8_4.diff !== 8'h00 || if8_4.bout !== 1'b0) begin
      errs++;
      $display("FAIL step4_10m0f: got %h/%b want 00/0", if8_4.diff, if8_4.bout);
    end
    op8_4(8'h00, 8'hFF, 1'b1, cyc, busy_n);
    vecs++;
    if (if8_4.diff !== 8'h00 || if8_4.bout !== 1'b1) begin
      errs++;
      $display("FAIL step4_0mff: got %h/%b want 00/1", if8_4.diff, if8_4.bout);
    end
    op8_4(8'h7F, 8'h80, 1'b0, cyc, busy_n);
    vecs++;
    if (if8_4.diff !== 8'hFF || if8_4.bout !== 1'b1) begin
      errs++;
      $display("FAIL step4_7fm80: got %h/%b want ff/1", if8_4.diff, if8_4.bout);
    end
`ifdef SERIAL_SUB_OVF_EN
    vecs++;
    if (if8_4.ovf !== 1'b1) begin
      errs++;
      $display("FAIL step4_7fm80_ovf: got %b want 1", if8_4.ovf);
    end
`endif
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    int busy_low = 0;
    if8_1.x = 8'h33; if8_1.y = 8'h11; if8_1.bin = 1'b0; if8_1.start = 1'b1;
    step();
    for (int i = 1; i <= 8; i++) begin
      if8_1.start = 1'b1;
      if8_1.x = 8'hFF ^ 8'(i);
      if8_1.y = 8'(i);
      if8_1.bin = 1'b1;
      if (!if8_1.busy) busy_low++;
      step();
      if (if8_1.done) dones++;
    end
    if8_1.start = 1'b0;
    vecs++;
    if (dones !== 1 || busy_low !== 0) begin
      errs++;
      $display("FAIL ignore_pulses: dones=%0d busy_low=%0d want 1/0", dones, busy_low);
    end
    vecs++;
    if (if8_1.diff !== 8'h22 || if8_1.bout !== 1'b0) begin
      errs++;
      $display("FAIL ignore_result: got %h/%b want 22/0", if8_1.diff, if8_1.bout);
    end
    step();
    vecs++;
    if (if8_1.done !== 1'b0 || if8_1.busy !== 1'b0) begin
      errs++;
      $display("FAIL ignore_after: done=%b busy=%b want 0/0", if8_1.done, if8_1.busy);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, busy_n;
    int changed = 0;
    op8_1(8'h90, 8'h10, 1'b0, cyc, busy_n);
    vecs++;
    if (if8_1.done !== 1'b1 || if8_1.diff !== 8'h80 || if8_1.bout !== 1'b0) begin
      errs++;
      $display("FAIL b2b_first: done=%b diff=%h bout=%b want 1/80/0",
               if8_1.done, if8_1.diff, if8_1.bout);
    end
    // Start issued in the done cycle itself.
    if8_1.x = 8'h05; if8_1.y = 8'h07; if8_1.bin = 1'b0; if8_1.start = 1'b1;
    step();
    if8_1.start = 1'b0;
    if8_1.x = 8'hAA; if8_1.y = 8'h00;
    cyc = 0;
    while (!if8_1.done && cyc < 40) begin
      if (if8_1.diff !== 8'h80) changed++;
      step();
      cyc++;
    end
    vecs++;
    if (cyc !== 8 || changed !== 0) begin
      errs++;
      $display("FAIL b2b_timing: cyc=%0d early_changes=%0d want 8/0", cyc, changed);
    end
    vecs++;
    if (if8_1.diff !== 8'hFE || if8_1.bout !== 1'b1) begin
      errs++;
      $display("FAIL b2b_second: got %h/%b want fe/1", if8_1.diff, if8_1.bout);
    end
`ifdef SERIAL_SUB_OVF_EN
    vecs++;
    if (if8_1.ovf !== 1'b0) begin
      errs++;
      $display("FAIL b2b_ovf: got %b want 0", if8_1.ovf);
    end
`endif
  endtask

  task automatic test_exhaustive_w2();
    int cyc1, cyc2, ref_d, ref_sd;
    logic ref_b, ref_o;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        for (int c = 0; c < 2; c++) begin
          ref_d  = (a - b - c) & 3;
          ref_b  = (a < b + c);
          ref_sd = ((a >= 2) ? a - 4 : a) - ((b >= 2) ? b - 4 : b) - c;
          ref_o  = (ref_sd < -2 || ref_sd > 1);
          op2_1(2'(a), 2'(b), 1'(c), cyc1);
          op2_2(2'(a), 2'(b), 1'(c), cyc2);
          vecs++;
          if (cyc1 !== 2 || if2_1.diff !== 2'(ref_d) || if2_1.bout !== ref_b) begin
            errs++;
            $display("FAIL w2s1 %0d-%0d-%0d: cyc=%0d diff=%0d bout=%b want 2/%0d/%b",
                     a, b, c, cyc1, if2_1.diff, if2_1.bout, ref_d, ref_b);
          end
          vecs++;
          if (cyc2 !== 1 || if2_2.diff !== 2'(ref_d) || if2_2.bout !== ref_b) begin
            errs++;
            $display("FAIL w2s2 %0d-%0d-%0d: cyc=%0d diff=%0d bout=%b want 1/%0d/%b",
                     a, b, c, cyc2, if2_2.diff, if2_2.bout, ref_d, ref_b);
          end
`ifdef SERIAL_SUB_OVF_EN
          vecs++;
          if (if2_1.ovf !== ref_o || if2_2.ovf !== ref_o) begin
            errs++;
            $display("FAIL w2_ovf %0d-%0d-%0d: got %b/%b want %b",
                     a, b, c, if2_1.ovf, if2_2.ovf, ref_o);
          end
`else
          ref_o = 1'b0;
`endif
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    int late_done = 0;
    int late_busy = 0;
    if8_1.x = 8'h5A; if8_1.y = 8'h3C; if8_1.bin = 1'b0; if8_1.start = 1'b1;
    step();
    if8_1.start = 1'b0;
    step(); step(); step();
    vecs++;
    if (if8_1.busy !== 1'b1) begin
      errs++;
      $display("FAIL abort_pre: busy=%b want 1", if8_1.busy);
    end
    rst_n = 1'b0;
    #1;
    vecs++;
    if (if8_1.busy !== 1'b0 || if8_1.done !== 1'b0 || if8_1.diff !== 8'h00 || if8_1.bout !== 1'b0) begin
      errs++;
      $display("FAIL abort_reset: busy=%b done=%b diff=%h bout=%b want all zero",
               if8_1.busy, if8_1.done, if8_1.diff, if8_1.bout);
    end
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (if8_1.done) late_done++;
      if (if8_1.busy) late_busy++;
    end
    vecs++;
    if (late_done !== 0 || late_busy !== 0 || if8_1.diff !== 8'h00) begin
      errs++;
      $display("FAIL abort_after: dones=%0d busy=%0d diff=%h want 0/0/00",
               late_done, late_busy, if8_1.diff);
    end
  endtask

  initial begin
    if8_1.start = 1'b0; if8_1.x = '0; if8_1.y = '0; if8_1.bin = 1'b0;
    if8_4.start = 1'b0; if8_4.x = '0; if8_4.y = '0; if8_4.bin = 1'b0;
    if2_1.start = 1'b0; if2_1.x = '0; if2_1.y = '0; if2_1.bin = 1'b0;
    if2_2.start = 1'b0; if2_2.x = '0; if2_2.y = '0; if2_2.bin = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_step4();
    test_ignore_start();
    test_back_to_back();
    test_exhaustive_w2();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
